// File: rtl/xadac_vrf_pipe_pkg.sv
// Shared types for the xadac vector register file stage.
// The optional operand forwarding is selected by XADAC_VRF_FWD_EN in xadac_vrf_pipe.
package xadac_vrf_pipe_pkg;

    localparam int unsigned NoVs   = 2;
    localparam int unsigned NoRs   = 2;
    localparam int unsigned NoRegs = 32;
    localparam int unsigned XLen   = 32;
    localparam int unsigned VLen   = 64;

    typedef logic [VLen-1:0]            VectorT;
    typedef logic [XLen-1:0]            WordT;
    typedef logic [$clog2(NoRegs)-1:0]  RegIdT;
    typedef logic [4:0]                 RegAddrT;
    typedef logic [3:0]                 IdT;
    typedef logic [31:0]                InstrT;

    typedef struct packed {
        IdT    id;
        InstrT instr;
    } DecReqT;

    typedef struct packed {
        IdT   id;
        logic accept;
        logic vd_write;
    } DecRspT;

    // On the issue side vs_data holds source register ids, on the vector side the operands.
    typedef struct packed {
        IdT                     id;
        InstrT                  instr;
        RegAddrT [NoRs-1:0]     rs_addr;
        WordT    [NoRs-1:0]     rs_data;
        RegIdT   [NoVs-1:0]     vs_addr;
        VectorT  [NoVs-1:0]     vs_data;
    } VrfEntryT;

    typedef struct packed {
        IdT     id;
        WordT   rd;
        logic   rd_write;
        RegIdT  vd_id;
        VectorT vd;
        logic   vd_write;
    } ExeRspT;

endpackage

// File: rtl/xadac_vrf_pipe_if.sv
// Decode/execute handshake bundle between issue side, VRF stage and vector unit.
interface xadac_vrf_pipe_if;
    import xadac_vrf_pipe_pkg::*;

    logic     dec_req_valid;
    logic     dec_req_ready;
    DecReqT   dec_req;
    logic     dec_rsp_valid;
    logic     dec_rsp_ready;
    DecRspT   dec_rsp;
    logic     exe_req_valid;
    logic     exe_req_ready;
    VrfEntryT exe_req;
    logic     exe_rsp_valid;
    logic     exe_rsp_ready;
    ExeRspT   exe_rsp;

    modport mst (
        output dec_req_valid, dec_req, dec_rsp_ready, exe_req_valid, exe_req, exe_rsp_ready,
        input  dec_req_ready, dec_rsp_valid, dec_rsp, exe_req_ready, exe_rsp_valid, exe_rsp
    );

    modport slv (
        input  dec_req_valid, dec_req, dec_rsp_ready, exe_req_valid, exe_req, exe_rsp_ready,
        output dec_req_ready, dec_rsp_valid, dec_rsp, exe_req_ready, exe_rsp_valid, exe_rsp
    );

endinterface

// File: rtl/xadac_vrf_pipe_bank.sv
// Vector register array: NoRd synchronous write-first read ports, one write port.
module xadac_vrf_bank #(
    parameter int unsigned NoRegs = 32,
    parameter int unsigned NoRd   = 2,
    parameter int unsigned VW     = 64,
    parameter int unsigned IdW    = 5
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     i_we,
    input  logic [IdW-1:0]           i_waddr,
    input  logic [VW-1:0]            i_wdata,
    input  logic                     i_re,
    input  logic [NoRd-1:0][VW-1:0]  i_raddr,
    output logic [NoRd-1:0][VW-1:0]  o_rdata
);

    logic [VW-1:0]           r_mem [NoRegs];
    logic [NoRd-1:0][VW-1:0] r_rdata;
    logic                    w_wvalid;

    assign w_wvalid = i_we && (32'(i_waddr) < NoRegs);
    assign o_rdata  = r_rdata;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NoRegs; i++) r_mem[i] <= '0;
            r_rdata <= '0;
        end else begin
            if (w_wvalid) r_mem[i_waddr] <= i_wdata;
            if (i_re) begin
                // Full-width id compare so aliased upper bits never hit a real register.
                for (int unsigned l = 0; l < NoRd; l++) begin
                    if (i_raddr[l] >= VW'(NoRegs))
                        r_rdata[l] <= '0;
                    else if (w_wvalid && (i_waddr == i_raddr[l][IdW-1:0]))
                        r_rdata[l] <= i_wdata;
                    else
                        r_rdata[l] <= r_mem[i_raddr[l][IdW-1:0]];
                end
            end
        end
    end

endmodule

// File: rtl/xadac_vrf_pipe.sv
// VRF stage: resolves source ids to operands, buffers issued requests, writes back results.
// Define XADAC_VRF_FWD_EN to patch buffered operands with later writes.
module xadac_vrf_pipe #(
    parameter int unsigned NoVs   = xadac_vrf_pipe_pkg::NoVs,
    parameter int unsigned NoRegs = xadac_vrf_pipe_pkg::NoRegs,
    parameter int unsigned Depth  = 2
) (
    input logic           clk,
    input logic           rstn,
    xadac_vrf_pipe_if.slv slv,
    xadac_vrf_pipe_if.mst mst
);
    import xadac_vrf_pipe_pkg::*;

    localparam int unsigned IdW  = (NoRegs > 1) ? $clog2(NoRegs) : 1;
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    assign mst.dec_req_valid = slv.dec_req_valid;
    assign mst.dec_req       = slv.dec_req;
    assign slv.dec_req_ready = mst.dec_req_ready;
    assign slv.dec_rsp_valid = mst.dec_rsp_valid;
    assign slv.dec_rsp       = mst.dec_rsp;
    assign mst.dec_rsp_ready = slv.dec_rsp_ready;
    assign slv.exe_rsp_valid = mst.exe_rsp_valid;
    assign slv.exe_rsp       = mst.exe_rsp;
    assign mst.exe_rsp_ready = slv.exe_rsp_ready;

    logic                    w_accept, w_fifo_empty, w_pop, w_s1_take, w_push;
    logic                    w_wr_ok;
    logic [IdW-1:0]          w_wid;
    VectorT [NoVs-1:0]       w_bank_rdata, w_s1_vs;
    VrfEntryT                w_s1_req;

    logic                    r_s1_valid;
    IdT                      r_s1_id;
    InstrT                   r_s1_instr;
    RegAddrT [NoRs-1:0]      r_s1_rs_addr;
    WordT    [NoRs-1:0]      r_s1_rs_data;
    RegIdT   [NoVs-1:0]      r_s1_vs_addr;

    VrfEntryT                r_fifo [Depth];
    logic [PtrW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CntW-1:0]         r_cnt;

    assign w_accept          = slv.exe_req_valid && slv.exe_req_ready;
    assign slv.exe_req_ready = (32'(r_cnt) + 32'(r_s1_valid)) < Depth;
    assign w_fifo_empty      = (r_cnt == '0);
    assign w_pop             = !w_fifo_empty && mst.exe_req_ready;
    assign w_s1_take         = r_s1_valid && w_fifo_empty && mst.exe_req_ready;
    assign w_push            = r_s1_valid && !w_s1_take;

    assign w_wid   = IdW'(mst.exe_rsp.vd_id);
    assign w_wr_ok = mst.exe_rsp_valid && mst.exe_rsp_ready && mst.exe_rsp.vd_write
                     && (32'(mst.exe_rsp.vd_id) < NoRegs);

    xadac_vrf_bank #(
        .NoRegs (NoRegs),
        .NoRd   (NoVs),
        .VW     (VLen),
        .IdW    (IdW)
    ) u_bank (
        .clk     (clk),
        .rstn    (rstn),
        .i_we    (w_wr_ok),
        .i_waddr (w_wid),
        .i_wdata (mst.exe_rsp.vd),
        .i_re    (w_accept),
        .i_raddr (slv.exe_req.vs_data),
        .o_rdata (w_bank_rdata)
    );

`ifdef XADAC_VRF_FWD_EN
    logic [NoVs-1:0][IdW-1:0] w_rid;
    logic [NoVs-1:0]          w_rid_ok;
    logic [NoVs-1:0][IdW-1:0] r_s1_vid;
    logic [NoVs-1:0]          r_s1_vok;
    logic [NoVs-1:0][IdW-1:0] r_fifo_vid [Depth];
    logic [NoVs-1:0]          r_fifo_vok [Depth];

    always_comb begin
        w_rid    = '0;
        w_rid_ok = '0;
        for (int unsigned l = 0; l < NoVs; l++) begin
            w_rid[l]    = IdW'(slv.exe_req.vs_data[l]);
            w_rid_ok[l] = slv.exe_req.vs_data[l] < VectorT'(NoRegs);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_vid <= '0;
            r_s1_vok <= '0;
        end else if (w_accept) begin
            r_s1_vid <= w_rid;
            r_s1_vok <= w_rid_ok;
        end
    end
`endif

    // Array data is only valid the cycle after the read; a write landing then is patched in here.
    always_comb begin
        w_s1_vs = w_bank_rdata;
`ifdef XADAC_VRF_FWD_EN
        for (int unsigned l = 0; l < NoVs; l++) begin
            if (w_wr_ok && r_s1_vok[l] && (r_s1_vid[l] == w_wid)) w_s1_vs[l] = mst.exe_rsp.vd;
        end
`endif
    end

    always_comb begin
        w_s1_req         = '0;
        w_s1_req.id      = r_s1_id;
        w_s1_req.instr   = r_s1_instr;
        w_s1_req.rs_addr = r_s1_rs_addr;
        w_s1_req.rs_data = r_s1_rs_data;
        w_s1_req.vs_addr = r_s1_vs_addr;
        w_s1_req.vs_data = w_s1_vs;
    end

    assign mst.exe_req_valid = r_s1_valid || !w_fifo_empty;
    assign mst.exe_req       = w_fifo_empty ? w_s1_req : r_fifo[r_rd_ptr];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_s1_valid   <= '0;
            r_s1_id      <= '0;
            r_s1_instr   <= '0;
            r_s1_rs_addr <= '0;
            r_s1_rs_data <= '0;
            r_s1_vs_addr <= '0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_id      <= slv.exe_req.id;
                r_s1_instr   <= slv.exe_req.instr;
                r_s1_rs_addr <= slv.exe_req.rs_addr;
                r_s1_rs_data <= slv.exe_req.rs_data;
                r_s1_vs_addr <= slv.exe_req.vs_addr;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned e = 0; e < Depth; e++) r_fifo[e] <= '0;
`ifdef XADAC_VRF_FWD_EN
            for (int unsigned e = 0; e < Depth; e++) begin
                r_fifo_vid[e] <= '0;
                r_fifo_vok[e] <= '0;
            end
`endif
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
`ifdef XADAC_VRF_FWD_EN
            // Patch first; a same-cycle push targets a free slot and overrides below.
            for (int unsigned e = 0; e < Depth; e++) begin
                for (int unsigned l = 0; l < NoVs; l++) begin
                    if (w_wr_ok && r_fifo_vok[e][l] && (r_fifo_vid[e][l] == w_wid))
                        r_fifo[e].vs_data[l] <= mst.exe_rsp.vd;
                end
            end
            if (w_push) begin
                r_fifo_vid[r_wr_ptr] <= r_s1_vid;
                r_fifo_vok[r_wr_ptr] <= r_s1_vok;
            end
`endif
            if (w_push) begin
                r_fifo[r_wr_ptr] <= w_s1_req;
                r_wr_ptr <= (r_wr_ptr == PtrW'(Depth - 1)) ? '0 : r_wr_ptr + PtrW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PtrW'(Depth - 1)) ? '0 : r_rd_ptr + PtrW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + CntW'(1);
                2'b01:   r_cnt <= r_cnt - CntW'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_xadac_vrf_pipe.sv
// Directed bench for xadac_vrf_pipe: table of write/read vectors plus multi-cycle sequences.
`timescale 1ns/1ps
module tb_xadac_vrf_pipe;
    import xadac_vrf_pipe_pkg::*;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    xadac_vrf_pipe_if s_if ();
    xadac_vrf_pipe_if m_if ();

    xadac_vrf_pipe #(
        .NoVs   (NoVs),
        .NoRegs (NoRegs),
        .Depth  (2)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .slv  (s_if),
        .mst  (m_if)
    );

    typedef struct {
        logic   rsp_v;
        logic   rsp_rdy;
        logic   vd_wr;
        RegIdT  wid;
        VectorT wdat;
        VectorT rid0;
        VectorT rid1;
        VectorT exp0;
        VectorT exp1;
    } vec_t;

    localparam VectorT A5 = 64'hA5A5_A5A5_A5A5_A5A5;
    localparam VectorT HI = 64'hFFFF_0000_FFFF_0000;

    vec_t tbl [8];
    int   n_pass = 0;
    int   n_chk  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_reg(input RegIdT id, input VectorT d);
        ExeRspT r;
        r          = '0;
        r.vd_id    = id;
        r.vd       = d;
        r.vd_write = 1'b1;
        m_if.exe_rsp       = r;
        m_if.exe_rsp_valid = 1'b1;
        s_if.exe_rsp_ready = 1'b1;
        step();
        m_if.exe_rsp_valid = 1'b0;
    endtask

    task automatic send_req(input IdT id, input VectorT v0, input VectorT v1);
        VrfEntryT q;
        q            = '0;
        q.id         = id;
        q.instr      = 32'h0000_1000 | 32'(id);
        q.vs_data[0] = v0;
        q.vs_data[1] = v1;
        s_if.exe_req       = q;
        s_if.exe_req_valid = 1'b1;
    endtask

    initial begin
        VrfEntryT req;
        ExeRspT   rsp;
        DecReqT   dreq;
        DecRspT   drsp;
        logic     dv, dr, rv, rr;
        IdT       seen_id [3];
        VectorT   seen_vs [3];
        int       got, vcnt;
        logic     acc;
        VectorT   exp_a, exp_b;

        tbl[0] = '{1'b1, 1'b1, 1'b1, 5'd3,  A5,             64'd1,  64'd2,  64'd0,    64'd0};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 5'd3,  64'hFFFF,       64'd3,  64'd0,  A5,       64'd0};
        tbl[2] = '{1'b1, 1'b1, 1'b1, 5'd5,  64'h11,         64'd5,  64'd3,  64'h11,   A5};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 5'd3,  64'hDEAD,       64'd3,  64'd5,  A5,       64'h11};
        tbl[4] = '{1'b1, 1'b0, 1'b1, 5'd3,  64'hBEEF,       64'd3,  64'd3,  A5,       A5};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 5'd31, HI,             64'd31, 64'd0,  HI,       64'd0};
        tbl[6] = '{1'b0, 1'b1, 1'b0, 5'd0,  64'd0,          64'd35, 64'd31, 64'd0,    HI};
        tbl[7] = '{1'b1, 1'b1, 1'b1, 5'd0,  64'h1234,       64'd0,  64'd0,  64'h1234, 64'h1234};

        s_if.dec_req_valid = 1'b0;
        s_if.dec_req       = '0;
        s_if.dec_rsp_ready = 1'b0;
        s_if.exe_req_valid = 1'b0;
        s_if.exe_req       = '0;
        s_if.exe_rsp_ready = 1'b0;
        m_if.dec_req_ready = 1'b0;
        m_if.dec_rsp_valid = 1'b0;
        m_if.dec_rsp       = '0;
        m_if.exe_req_ready = 1'b1;
        m_if.exe_rsp_valid = 1'b0;
        m_if.exe_rsp       = '0;

        #1;
        chk("rst_valid", 128'(m_if.exe_req_valid), 128'(0));
        chk("rst_ready", 128'(s_if.exe_req_ready), 128'(1));
        step();
        step();
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) begin
            dv = i[0]; dr = ~i[0]; rv = i[1]; rr = i[2];
            dreq = '{id: IdT'(i), instr: 32'hCAFE_0000 | 32'(i)};
            drsp = '{id: IdT'(i), accept: i[1], vd_write: i[0]};
            s_if.dec_req_valid = dv;
            s_if.dec_req       = dreq;
            m_if.dec_req_ready = dr;
            m_if.dec_rsp_valid = rv;
            m_if.dec_rsp       = drsp;
            s_if.dec_rsp_ready = rr;

            rsp          = '0;
            rsp.id       = IdT'(i);
            rsp.rd       = 32'hC0DE_0000 | 32'(i);
            rsp.rd_write = i[0];
            rsp.vd_id    = tbl[i].wid;
            rsp.vd       = tbl[i].wdat;
            rsp.vd_write = tbl[i].vd_wr;
            m_if.exe_rsp       = rsp;
            m_if.exe_rsp_valid = tbl[i].rsp_v;
            s_if.exe_rsp_ready = tbl[i].rsp_rdy;

            req            = '0;
            req.id         = IdT'(i);
            req.instr      = 32'h0000_1000 | 32'(i);
            req.rs_data[0] = WordT'(i * 3);
            req.vs_data[0] = tbl[i].rid0;
            req.vs_data[1] = tbl[i].rid1;
            s_if.exe_req       = req;
            s_if.exe_req_valid = 1'b1;
            #1;
            if (i == 0) chk("first_pre_valid", 128'(m_if.exe_req_valid), 128'(0));
            chk("dec_req_fwd", 128'({m_if.dec_req_valid, m_if.dec_req}), 128'({dv, dreq}));
            chk("dec_rdy_fwd", 128'(s_if.dec_req_ready), 128'(dr));
            chk("dec_rsp_fwd", 128'({s_if.dec_rsp_valid, s_if.dec_rsp, m_if.dec_rsp_ready}),
                128'({rv, drsp, rr}));
            chk("exe_rsp_fwd", 128'({s_if.exe_rsp_valid, s_if.exe_rsp, m_if.exe_rsp_ready}),
                128'({tbl[i].rsp_v, rsp, tbl[i].rsp_rdy}));
            chk("tbl_ready", 128'(s_if.exe_req_ready), 128'(1));
            @(posedge clk);
            #1;
            chk("tbl_valid", 128'(m_if.exe_req_valid), 128'(1));
            chk("tbl_id", 128'({m_if.exe_req.id, m_if.exe_req.instr, m_if.exe_req.rs_data[0]}),
                128'({IdT'(i), 32'h0000_1000 | 32'(i), WordT'(i * 3)}));
            chk("tbl_vs0", 128'(m_if.exe_req.vs_data[0]), 128'(tbl[i].exp0));
            chk("tbl_vs1", 128'(m_if.exe_req.vs_data[1]), 128'(tbl[i].exp1));
        end
        s_if.exe_req_valid = 1'b0;
        m_if.exe_rsp_valid = 1'b0;
        step();
        chk("drain_valid", 128'(m_if.exe_req_valid), 128'(0));

        // Back-pressure: three back-to-back requests into a stalled Depth=2 stage.
        m_if.exe_req_ready = 1'b0;
        send_req(4'd0, 64'd3, 64'd5);
        step();
        chk("bp_rdy_1", 128'(s_if.exe_req_ready), 128'(1));
        send_req(4'd1, 64'd3, 64'd5);
        step();
        chk("bp_rdy_full", 128'(s_if.exe_req_ready), 128'(0));
        send_req(4'd2, 64'd3, 64'd5);
        step();
        chk("bp_rdy_hold", 128'(s_if.exe_req_ready), 128'(0));
        chk("bp_head", 128'({m_if.exe_req_valid, m_if.exe_req.id}), 128'({1'b1, 4'd0}));
        step();
        chk("bp_rdy_hold2", 128'(s_if.exe_req_ready), 128'(0));
        m_if.exe_req_ready = 1'b1;
        #1;
        got = 0;
        for (int c = 0; c < 12 && got < 3; c++) begin
            if (m_if.exe_req_valid) begin
                seen_id[got] = m_if.exe_req.id;
                seen_vs[got] = m_if.exe_req.vs_data[0];
                got++;
            end
            acc = s_if.exe_req_valid && s_if.exe_req_ready;
            @(posedge clk);
            #1;
            if (acc) s_if.exe_req_valid = 1'b0;
            #1;
        end
        chk("bp_count", 128'(got), 128'(3));
        for (int k = 0; k < 3; k++) begin
            if (k < got) begin
                chk("bp_order", 128'(seen_id[k]), 128'(k));
                chk("bp_data", 128'(seen_vs[k]), 128'(A5));
            end
        end
        step();
        chk("bp_drain", 128'(m_if.exe_req_valid), 128'(0));

        // Writes landing while operands sit in S1 and in the buffer.
        wr_reg(5'd7, 64'h77);
        wr_reg(5'd6, 64'h66);
        m_if.exe_req_ready = 1'b0;
        send_req(4'd4, 64'd7, 64'd0);
        step();
        send_req(4'd5, 64'd6, 64'd0);
        step();
        s_if.exe_req_valid = 1'b0;
        wr_reg(5'd6, 64'h33);
        wr_reg(5'd7, 64'h22);
`ifdef XADAC_VRF_FWD_EN
        exp_a = 64'h22;
        exp_b = 64'h33;
`else
        exp_a = 64'h77;
        exp_b = 64'h66;
`endif
        m_if.exe_req_ready = 1'b1;
        #1;
        chk("fwd_a", 128'({m_if.exe_req_valid, m_if.exe_req.id, m_if.exe_req.vs_data[0]}),
            128'({1'b1, 4'd4, exp_a}));
        step();
        chk("fwd_b", 128'({m_if.exe_req_valid, m_if.exe_req.id, m_if.exe_req.vs_data[0]}),
            128'({1'b1, 4'd5, exp_b}));
        step();
        chk("fwd_drain", 128'(m_if.exe_req_valid), 128'(0));

        // Reset with two requests buffered.
        m_if.exe_req_ready = 1'b0;
        send_req(4'd8, 64'd3, 64'd5);
        step();
        send_req(4'd9, 64'd3, 64'd5);
        step();
        s_if.exe_req_valid = 1'b0;
        #3;
        rstn = 1'b0;
        #1;
        chk("mid_rst_valid", 128'(m_if.exe_req_valid), 128'(0));
        @(posedge clk);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        #1;
        chk("post_rst_ready", 128'(s_if.exe_req_ready), 128'(1));
        chk("post_rst_valid", 128'(m_if.exe_req_valid), 128'(0));
        m_if.exe_req_ready = 1'b1;
        vcnt = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (m_if.exe_req_valid) vcnt++;
        end
        chk("post_rst_stale", 128'(vcnt), 128'(0));
        send_req(4'd1, 64'd3, 64'd5);
        step();
        s_if.exe_req_valid = 1'b0;
        chk("post_rst_read", 128'({m_if.exe_req_valid, m_if.exe_req.vs_data[0], m_if.exe_req.vs_data[1]}),
            128'({1'b1, 64'd0, 64'd0}));
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
